// File: rtl/scramble_sequencer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scramble_sequencer_pkg
// Description : Shared state encoding, move type and move decode helpers for
//               the cell-array scramble sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
package scramble_sequencer_pkg;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_DRAW   = 3'd1;
    localparam logic [2:0] ST_FIRE   = 3'd2;
    localparam logic [2:0] ST_GAP    = 3'd3;
    localparam logic [2:0] ST_FINISH = 3'd4;

    // sel: 0 = row, 1 = column; idx selects which of the four lines.
    typedef struct packed {
        logic       sel;
        logic [1:0] idx;
    } move_t;

    // Returns {row[3:0], col[3:0]} with exactly one line set.
    function automatic logic [7:0] decode_move(input move_t m);
        logic [3:0] w_onehot;
        w_onehot = 4'b0001 << m.idx;
        return m.sel ? {4'b0000, w_onehot} : {w_onehot, 4'b0000};
    endfunction

    function automatic logic [1:0] onehot_to_idx(input logic [3:0] onehot);
        logic [1:0] w_idx;
        case (onehot)
            4'b0010: w_idx = 2'd1;
            4'b0100: w_idx = 2'd2;
            4'b1000: w_idx = 2'd3;
            default: w_idx = 2'd0;
        endcase
        return w_idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scramble_sequencer_move_decoder.sv
`default_nettype none
// ============================================================================
// Module      : move_decoder
// Description : Combinational 3-bit move to one-hot row/col decoder, shared by
//               the user selection path and the random scramble path.
// Revision    : 1.0 - initial release
// ============================================================================
module move_decoder
    import scramble_sequencer_pkg::*;
(
    input  move_t      move,
    input  logic       enable,
    output logic [3:0] row,
    output logic [3:0] col
);

    logic [7:0] w_lines;

    always_comb begin
        w_lines = decode_move(move);
        if (!enable) begin
            w_lines = 8'h00;
        end
    end

    assign row = w_lines[7:4];
    assign col = w_lines[3:0];

endmodule
`default_nettype wire

// File: rtl/scramble_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : scramble_sequencer
// Description : Forwards user row/col/fire to the cell array in idle, and on a
//               start pulse issues a spaced sequence of pseudo-random moves.
// Revision    : 1.0 - initial release
// ============================================================================
module scramble_sequencer
    import scramble_sequencer_pkg::*;
#(
    parameter int NUM_MOVES  = 16,
    parameter int GAP_CYCLES = 15,
    parameter int MAX_RETRY  = 3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [2:0] random_num,
    input  logic [3:0] user_rc,
    input  logic       user_nrow,
    input  logic       user_error,
    input  logic       user_fire,
    output logic [3:0] row,
    output logic [3:0] col,
    output logic       fire,
    output logic       busy,
    output logic       done,
    output logic [7:0] moves_left
);

    localparam logic [7:0] C_NUM_MOVES  = 8'(NUM_MOVES);
    localparam logic [7:0] C_GAP_CYCLES = 8'(GAP_CYCLES);
    localparam logic [7:0] C_MAX_RETRY  = 8'(MAX_RETRY);
    localparam logic       C_NO_GAP     = (GAP_CYCLES == 0);

    logic [2:0] r_state;
    logic [3:0] r_row;
    logic [3:0] r_col;
    logic       r_fire;
    logic       r_busy;
    logic       r_done;
    logic [7:0] r_moves_left;
    logic [7:0] r_retry;
    logic [7:0] r_gap_cnt;
    move_t      r_move;
    move_t      r_prev_move;

    move_t      w_draw_move;
    move_t      w_user_move;
    logic       w_user_en;
    logic [3:0] w_draw_row;
    logic [3:0] w_draw_col;
    logic [3:0] w_user_row;
    logic [3:0] w_user_col;
    logic       w_redraw;

    assign w_draw_move = move_t'(random_num);

    // A switch error blanks the selection; the user one-hot is re-encoded
    // so the same decoder serves both paths.
    always_comb begin
        w_user_move     = '0;
        w_user_move.sel = user_nrow;
        w_user_move.idx = onehot_to_idx(user_rc);
    end
    assign w_user_en = (|user_rc) & ~user_error;

    move_decoder u_draw_decoder (
        .move   (w_draw_move),
        .enable (1'b1),
        .row    (w_draw_row),
        .col    (w_draw_col)
    );

    move_decoder u_user_decoder (
        .move   (w_user_move),
        .enable (w_user_en),
        .row    (w_user_row),
        .col    (w_user_col)
    );

    // Repeating the previous move would undo it, so redraw a bounded number of times.
    assign w_redraw = (w_draw_move == r_prev_move) && (r_retry < C_MAX_RETRY);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_row        <= 4'b0000;
            r_col        <= 4'b0000;
            r_fire       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_moves_left <= 8'd0;
            r_retry      <= 8'd0;
            r_gap_cnt    <= 8'd0;
            r_move       <= '0;
            r_prev_move  <= '0;
        end else begin
            r_fire <= 1'b0;
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state      <= ST_DRAW;
                        r_busy       <= 1'b1;
                        r_moves_left <= C_NUM_MOVES;
                        r_retry      <= 8'd0;
                        r_row        <= 4'b0000;
                        r_col        <= 4'b0000;
                    end else begin
                        r_row  <= w_user_row;
                        r_col  <= w_user_col;
                        r_fire <= user_fire & ~user_error;
                    end
                end
                ST_DRAW: begin
                    if (w_redraw) begin
                        r_retry <= r_retry + 8'd1;
                    end else begin
                        r_move  <= w_draw_move;
                        r_row   <= w_draw_row;
                        r_col   <= w_draw_col;
                        r_retry <= 8'd0;
                        r_state <= ST_FIRE;
                    end
                end
                ST_FIRE: begin
                    r_fire       <= 1'b1;
                    r_prev_move  <= r_move;
                    r_moves_left <= r_moves_left - 8'd1;
                    if (r_moves_left == 8'd1) begin
                        r_state <= ST_FINISH;
                    end else if (C_NO_GAP) begin
                        r_state <= ST_DRAW;
                    end else begin
                        r_gap_cnt <= C_GAP_CYCLES;
                        r_state   <= ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (r_gap_cnt <= 8'd1) begin
                        r_state <= ST_DRAW;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 8'd1;
                    end
                end
                ST_FINISH: begin
                    r_done      <= 1'b1;
                    r_busy      <= 1'b0;
                    r_row       <= 4'b0000;
                    r_col       <= 4'b0000;
                    r_prev_move <= '0;
                    r_state     <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign row        = r_row;
    assign col        = r_col;
    assign fire       = r_fire;
    assign busy       = r_busy;
    assign done       = r_done;
    assign moves_left = r_moves_left;

endmodule
`default_nettype wire
